// File: rtl/spart_port.sv
// spart_port: 8N1 serial port with a TX FIFO, a double-synchronized receiver and a status/data read mux.
module spart_port #(
    parameter int DIV   = 434,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        send,
    input  logic [7:0]  send_data,
    output logic        full,
    output logic        Spart_RCV,
    input  logic [2:0]  spart_addr,
    output logic [15:0] spart_data,
    output logic        txd,
    input  logic        rxd
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [4:0]    cnt_q;
    logic          push, pop;

    tx_state_t   tx_q, tx_d;
    logic [7:0]  tsh_q, tsh_d;
    logic [2:0]  tbit_q, tbit_d;
    logic [15:0] tdiv_q, tdiv_d;
    logic        txd_q, txd_d;
    logic        tdone;

    logic        s1_q, s2_q, prev_q;
    rx_state_t   rx_q, rx_d;
    logic [7:0]  rsh_q, rsh_d;
    logic [2:0]  rbit_q, rbit_d;
    logic [15:0] rdiv_q, rdiv_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [7:0]  rx_count_q, rx_count_d;
    logic        seen_q, seen_d, ferr_q, ferr_d, rcv_q, rcv_d;
    logic        rdone, rhalf;

    assign full  = cnt_q == 5'(DEPTH);
    assign push  = send && !full;
    assign pop   = tx_q == T_IDLE && cnt_q != 5'd0;
    assign txd   = txd_q;
    assign Spart_RCV = rcv_q;

    always_ff @(posedge clk)
        if (push)
            mem_q[wr_q] <= send_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_q + 5'(push) - 5'(pop);
        end
    end

    assign tdone = tdiv_q == 16'(DIV - 1);

    always_comb begin
        tx_d   = tx_q;
        tsh_d  = tsh_q;
        tbit_d = tbit_q;
        tdiv_d = tdiv_q + 16'd1;
        txd_d  = txd_q;
        case (tx_q)
            T_IDLE: begin
                tdiv_d = '0;
                if (pop) begin
                    tx_d  = T_START;
                    tsh_d = mem_q[rd_q];
                    txd_d = 1'b0;
                end
            end
            T_START:
                if (tdone) begin
                    tx_d   = T_DATA;
                    txd_d  = tsh_q[0];
                    tdiv_d = '0;
                    tbit_d = '0;
                end
            T_DATA:
                if (tdone) begin
                    tdiv_d = '0;
                    tbit_d = tbit_q + 3'd1;
                    tsh_d  = tsh_q >> 1;
                    txd_d  = tbit_q == 3'd7 ? 1'b1 : tsh_q[1];
                    tx_d   = tbit_q == 3'd7 ? T_STOP : T_DATA;
                end
            default:
                if (tdone) begin
                    tx_d   = T_IDLE;
                    tdiv_d = '0;
                end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_q   <= T_IDLE;
            tsh_q  <= '0;
            tbit_q <= '0;
            tdiv_q <= '0;
            txd_q  <= 1'b1;
        end else begin
            tx_q   <= tx_d;
            tsh_q  <= tsh_d;
            tbit_q <= tbit_d;
            tdiv_q <= tdiv_d;
            txd_q  <= txd_d;
        end
    end

    assign rdone = rdiv_q == 16'(DIV - 1);
    assign rhalf = rdiv_q == 16'(DIV / 2 - 1);

    always_comb begin
        rx_d       = rx_q;
        rsh_d      = rsh_q;
        rbit_d     = rbit_q;
        rdiv_d     = rdiv_q + 16'd1;
        rx_data_d  = rx_data_q;
        rx_count_d = rx_count_q;
        seen_d     = seen_q;
        ferr_d     = ferr_q;
        rcv_d      = 1'b0;
        case (rx_q)
            R_IDLE: begin
                rdiv_d = '0;
                rx_d   = prev_q && !s2_q ? R_START : R_IDLE;
            end
            R_START:
                if (rhalf) begin
                    rdiv_d = '0;
                    rbit_d = '0;
                    rx_d   = s2_q ? R_IDLE : R_DATA;
                end
            R_DATA:
                if (rdone) begin
                    rdiv_d = '0;
                    rsh_d  = {s2_q, rsh_q[7:1]};
                    rbit_d = rbit_q + 3'd1;
                    rx_d   = rbit_q == 3'd7 ? R_STOP : R_DATA;
                end
            default:
                if (rdone) begin
                    rx_d       = R_IDLE;
                    rx_data_d  = s2_q ? rsh_q : rx_data_q;
                    rx_count_d = rx_count_q + 8'(s2_q);
                    seen_d     = seen_q | s2_q;
                    ferr_d     = ferr_q | !s2_q;
                    rcv_d      = s2_q;
                end
        endcase
    end

    // Only s2_q (and its delayed copy prev_q) is ever looked at by the receiver.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            prev_q     <= 1'b1;
            rx_q       <= R_IDLE;
            rsh_q      <= '0;
            rbit_q     <= '0;
            rdiv_q     <= '0;
            rx_data_q  <= '0;
            rx_count_q <= '0;
            seen_q     <= 1'b0;
            ferr_q     <= 1'b0;
            rcv_q      <= 1'b0;
        end else begin
            s1_q       <= rxd;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            rx_q       <= rx_d;
            rsh_q      <= rsh_d;
            rbit_q     <= rbit_d;
            rdiv_q     <= rdiv_d;
            rx_data_q  <= rx_data_d;
            rx_count_q <= rx_count_d;
            seen_q     <= seen_d;
            ferr_q     <= ferr_d;
            rcv_q      <= rcv_d;
        end
    end

    assign spart_data = spart_addr == 3'd0 ? {8'h00, rx_data_q} :
                        spart_addr == 3'd1 ? {ferr_q, tx_q != T_IDLE, full, seen_q, 7'b0, cnt_q} :
                        spart_addr == 3'd2 ? {8'h00, rx_count_q} :
                        spart_addr == 3'd3 ? 16'(DIV) : 16'h0000;
endmodule

// File: tb/tb_spart_port.sv
// tb_spart_port: randomized scoreboard bench; serial monitors decode txd and Spart_RCV against queued expectations.
module tb_spart_port;
    localparam int DIV = 16;
    localparam int DEPTH = 8;

    logic clk = 0, rst = 0, send = 0;
    logic [7:0] send_data = 0;
    logic [2:0] spart_addr = 0;
    logic full, Spart_RCV, txd, rxd;
    logic [15:0] spart_data;
    logic rx_drv = 1, loop = 0, drop = 0;
    int n_chk = 0, n_fail = 0, cyc = 0, rcv_cnt = 0;
    logic [7:0] tx_exp[$], rx_exp[$];

    assign rxd = loop ? txd : rx_drv;

    spart_port #(.DIV(DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .send(send), .send_data(send_data), .full(full),
        .Spart_RCV(Spart_RCV), .spart_addr(spart_addr), .spart_data(spart_data),
        .txd(txd), .rxd(rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        spart_addr = a;
        #1;
        d = spart_data;
        spart_addr = 0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stp);
        logic [9:0] f;
        f = {stp, b, 1'b0};
        if (stp) rx_exp.push_back(b);
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (DIV) tick();
        end
        rx_drv = 1;
    endtask

    // TX monitor: decodes each frame at bit centres and compares with the queued byte.
    initial begin
        logic [7:0] b;
        logic stp;
        forever begin
            @(negedge clk);
            if (txd === 1'b0 && rst === 1'b1) begin
                repeat (DIV / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (DIV) @(negedge clk);
                stp = txd;
                if (!drop) begin
                    if (tx_exp.size() == 0) check("tx_unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
                    else begin
                        check("tx_byte", b, tx_exp.pop_front());
                        check("tx_stop", stp, 1);
                    end
                end
            end
        end
    end

    // RX monitor: every Spart_RCV pulse must carry the next expected byte and last one cycle.
    initial begin
        logic prev = 0;
        forever begin
            @(negedge clk);
            if (Spart_RCV === 1'b1) begin
                rcv_cnt++;
                if (prev) check("rcv_pulse_width", 2, 1);
                if (rx_exp.size() == 0) check("rx_unexpected_pulse", spart_data, 32'hFFFF_FFFF);
                else check("rx_byte", spart_data, {24'h0, rx_exp.pop_front()});
            end
            prev = Spart_RCV === 1'b1;
        end
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        logic [15:0] d;
        logic [9:0] fr;
        logic [7:0] b;
        int t0, t, base;
        repeat (3) tick();
        rst = 1;
        check("reset_txd", txd, 1);
        check("reset_full", full, 0);
        check("reset_rcv", Spart_RCV, 0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            check("reset_reg", d, a == 3 ? 32'(DIV) : 0);
        end

        // single 0xA5 frame, cycle by cycle
        send_data = 8'hA5;
        send = 1;
        tx_exp.push_back(8'hA5);
        tick();
        send = 0;
        check("txd_before_start", txd, 1);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 10 * DIV; j++) begin
            tick();
            check("txd_bit", txd, fr[j / DIV]);
            rd(1, d);
            check("tx_busy", d[14], 1);
        end
        tick();
        check("txd_after_frame", txd, 1);
        rd(1, d);
        check("tx_busy_end", d[14], 0);

        // 10 back-to-back sends into an idle transmitter
        for (int i = 0; i < 10; i++) begin
            rd(1, d);
            check("burst_count", d[4:0], (i > 9 ? 9 : i) - (i >= 2 ? 1 : 0));
            check("burst_busy", d[14], i >= 2);
            check("burst_full", full, i == 9);
            b = 8'($urandom);
            send_data = b;
            send = 1;
            if (i < 9) tx_exp.push_back(b);
            tick();
        end
        send = 0;
        rd(1, d);
        check("burst_count_end", d[4:0], 8);
        check("burst_full_end", full, 1);
        for (t = 0; t < 2500 && tx_exp.size() != 0; t++) tick();
        check("tx_drain_pending", tx_exp.size(), 0);
        repeat (20) tick();
        rd(1, d);
        check("tx_drained_status", d, 0);

        // received 0x3C: latency and registers
        t0 = cyc;
        fork rx_frame(8'h3C, 1); join_none
        for (t = 0; t < 300 && Spart_RCV !== 1'b1; t++) tick();
        check("rx_latency_window", (cyc - t0 >= 9 * DIV + DIV / 2) && (cyc - t0 <= 9 * DIV + DIV / 2 + 6), 1);
        tick();
        check("rcv_one_cycle", Spart_RCV, 0);
        repeat (DIV + 4) tick();
        rd(0, d);
        check("rx_data_3c", d, 16'h003C);
        rd(2, d);
        check("rx_count_1", d, 16'h0001);
        check("rx_pulses_1", rcv_cnt, 1);

        // short low glitch is a false start
        rx_drv = 0;
        repeat (8) tick();
        rx_drv = 1;
        repeat (40) tick();
        check("glitch_pulses", rcv_cnt, 1);
        rd(1, d);
        check("glitch_status", d, 16'h1000);
        rd(0, d);
        check("glitch_rx_data", d, 16'h003C);

        // bad stop bit sets frame_err only
        rx_frame(8'h55, 0);
        repeat (20) tick();
        check("ferr_pulses", rcv_cnt, 1);
        rd(1, d);
        check("ferr_status", d, 16'h9000);
        rd(0, d);
        check("ferr_rx_data", d, 16'h003C);
        rd(2, d);
        check("ferr_rx_count", d, 16'h0001);

        // reset in the middle of a frame with 3 bytes queued
        drop = 1;
        for (int i = 0; i < 4; i++) begin
            send_data = 8'($urandom);
            send = 1;
            tick();
        end
        send = 0;
        repeat (40) tick();
        rd(1, d);
        check("pre_reset_count", d[4:0], 3);
        rst = 0;
        tick();
        rst = 1;
        check("abort_txd", txd, 1);
        check("abort_full", full, 0);
        check("abort_rcv", Spart_RCV, 0);
        rd(1, d);
        check("abort_status", d, 0);
        rd(0, d);
        check("abort_rx_data", d, 0);
        rd(2, d);
        check("abort_rx_count", d, 0);
        repeat (12 * DIV) tick();
        drop = 0;

        // loopback of 256 random bytes, rx_count wraps
        base = rcv_cnt;
        loop = 1;
        for (int i = 0; i < 256; i++) begin
            for (int w = 0; full && w < 400; w++) tick();
            b = 8'($urandom);
            tx_exp.push_back(b);
            rx_exp.push_back(b);
            send_data = b;
            send = 1;
            tick();
            send = 0;
            repeat ($urandom_range(0, 2)) tick();
        end
        for (t = 0; t < 3000 && rx_exp.size() != 0; t++) tick();
        repeat (DIV) tick();
        check("loop_rx_pending", rx_exp.size(), 0);
        check("loop_tx_pending", tx_exp.size(), 0);
        check("loop_pulses", rcv_cnt - base, 256);
        rd(2, d);
        check("rx_count_wrap", d, 16'h0000);
        rd(1, d);
        check("loop_status", d, 16'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spart_port.md
SPART_PORT -- requirements
Module: spart_port

Interface
REQ-001 SHALL have parameter DIV, default 434, meaning clocks per serial bit (16..65535).
REQ-002 SHALL have parameter DEPTH, default 8, meaning TX FIFO entries (power of 2, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-low (rst=0 resets on the next clk edge).
REQ-005 SHALL have port send  input  1  processor TX write strobe, one byte per cycle high.
REQ-006 SHALL have port send_data  input  8  byte to transmit, valid with send.
REQ-007 SHALL have port full  output  1  TX FIFO full; processor stalls while high.
REQ-008 SHALL have port Spart_RCV  output  1  one-cycle pulse per correctly framed received byte.
REQ-009 SHALL have port spart_addr  input  3  register select for spart_data.
REQ-010 SHALL have port spart_data  output  16  combinational register read data.
REQ-011 SHALL have port txd  output  1  serial out, idle high.
REQ-012 SHALL have port rxd  input  1  serial in, asynchronous, idle high.

Function
REQ-013 SHALL push send_data into the TX FIFO on an edge where send=1 and full=0; send=1 with full=1 SHALL be ignored, even if a pop occurs that cycle.
REQ-014 SHALL drive full combinationally as (tx_count == DEPTH); tx_count SHALL be 0..DEPTH, incrementing on push, decrementing on pop, unchanged on simultaneous push and pop.
REQ-015 SHALL run TX FSM with states T_IDLE, T_START, T_DATA, T_STOP; txd is a registered output.
REQ-016 SHALL, in T_IDLE with tx_count>0, pop the FIFO head into an 8-bit shift register, drive txd=0 and enter T_START.
REQ-017 SHALL hold each bit for exactly DIV cycles: start bit 0, 8 data bits LSB first (T_DATA), stop bit 1 (T_STOP); one frame is 10*DIV cycles.
REQ-018 SHALL return from T_STOP to T_IDLE for one cycle before starting the next frame; back-to-back frames are therefore 10*DIV+1 cycles apart.
REQ-019 SHALL have latency of 1 cycle from push into an empty FIFO with TX FSM idle to txd falling: push at edge k, txd=0 after edge k+1.
REQ-020 SHALL synchronize rxd through two flip-flops before use; RX logic SHALL see only the synchronized value.
REQ-021 SHALL run RX FSM with states R_IDLE, R_START, R_DATA, R_STOP.
REQ-022 SHALL leave R_IDLE on a synchronized 1->0 transition and sample at DIV/2 cycles; if the sample is 1 (false start), SHALL return to R_IDLE without side effects.
REQ-023 SHALL sample 8 data bits, LSB first, each DIV cycles after the previous sample, then the stop bit DIV cycles later.
REQ-024 SHALL, on stop sample=1: load rx_data, set rx_seen, increment 8-bit rx_count (wraps 255->0), and pulse Spart_RCV for exactly one cycle.
REQ-025 SHALL, on stop sample=0: set sticky frame_err, leave rx_data/rx_count unchanged, give no Spart_RCV pulse, and return to R_IDLE.
REQ-026 SHALL let a new byte overwrite rx_data; reads SHALL have no side effects.
REQ-027 SHALL decode spart_data by spart_addr:
- 0: {8'h00, rx_data}
- 1: {frame_err, tx_busy, full, rx_seen, 7'b0, tx_count[4:0]}
- 2: {8'h00, rx_count}
- 3: DIV[15:0]
- 4..7: 16'h0000
REQ-028 SHALL assert tx_busy when the TX FSM is not in T_IDLE.
REQ-029 SHALL run TX and RX fully independently; a simultaneous push, pop, and RX completion in one cycle SHALL all take effect.

Reset
REQ-030 SHALL, when rst=0 at an edge, empty the FIFO (tx_count=0, full=0), put TX FSM in T_IDLE with txd=1, and put RX FSM in R_IDLE with synchronizer flops=1.
REQ-031 SHALL clear rx_data, rx_count, rx_seen and frame_err, and drive Spart_RCV=0, on reset.
REQ-032 SHALL abort any in-flight TX/RX frame on reset mid-operation, with txd=1 from the following cycle; partial bytes are discarded.

Verification (DIV=16, DEPTH=8)
REQ-033 SHALL verify that a single send of 0xA5 gives txd low one cycle after push, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then stop high; tx_busy is high for 160 cycles.
REQ-034 SHALL verify that 9 sends on consecutive cycles with TX idle give: first byte popped at cycle 2, 8 held, full=1 after the 9th push; a 10th send is dropped; the FIFO drains in order.
REQ-035 SHALL verify that serial 0x3C on rxd gives one Spart_RCV pulse about 9.5*DIV+3 cycles after the start edge, spart_addr=0 reads 0x003C, and spart_addr=2 reads 0x0001.
REQ-036 SHALL verify that an 8-cycle low glitch on rxd gives no pulse and no state change, and that a frame with stop=0 gives frame_err=1 (spart_addr=1 bit15) and no pulse.
REQ-037 SHALL verify that rst=0 mid-TX-frame with 3 queued bytes gives txd=1, tx_count=0, full=0 and all status bits 0 on the next cycle.
REQ-038 SHALL verify that 256 received bytes make rx_count wrap to 0x00 while loopback txd->rxd returns every sent byte intact.
